exmem_stage: RTL and testbench

Execute-to-memory pipeline stage sitting directly downstream of the 16-bit ALU. Captures the ALU's result, flags and decoded op each cycle, owns the architectural HI/LO registers (written by mult/multu/div/divu, read by mfhi/mflo), and classifies each instruction for the memory/writeback side. Includes a 2-entry skid buffer so a stalled downstream never combinationally stalls the ALU.

---
 rtl/exmem_stage.sv | 180 ++++++++++++++++++
 tb/tb_exmem_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_stage.sv
// Execute-to-memory pipeline stage.
// Captures the ALU output, owns the architectural HI/LO registers, classifies
// each instruction for the memory/writeback side and buffers it in a
// main + skid register pair so a stalled memory stage never combinationally
// stalls the ALU.
// Optional feature macro: EXMEM_FLUSH_EN adds a synchronous flush input that
// invalidates both buffer entries and blocks acceptance in the same cycle.
module exmem_stage #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef EXMEM_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_op,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_hi,
  input  logic [DATA_W-1:0] in_lo,
  input  logic              in_zero,
  input  logic              in_sign,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_store_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic [DATA_W-1:0] out_store_data,
  output logic              out_branch_taken,
  output logic              out_zero,
  output logic              out_sign,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              we;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] store_data;
    logic              branch_taken;
    logic              zero;
    logic              sign;
  } entry_t;

  localparam logic [6:0] OP_MULT  = 7'b0000_010;
  localparam logic [6:0] OP_MULTU = 7'b0000_011;
  localparam logic [6:0] OP_DIV   = 7'b0001_010;
  localparam logic [6:0] OP_DIVU  = 7'b0001_011;
  localparam logic [6:0] OP_JR    = 7'b0001_111;
  localparam logic [6:0] OP_MFHI  = 7'b0010_110;
  localparam logic [6:0] OP_MFLO  = 7'b0010_111;
  localparam logic [3:0] OPC_BNEQ = 4'b0101;
  localparam logic [3:0] OPC_BGTZ = 4'b0110;
  localparam logic [3:0] OPC_LH   = 4'b1000;
  localparam logic [3:0] OPC_SH   = 4'b1001;

  entry_t            main_q, main_d;
  entry_t            skid_q, skid_d;
  entry_t            new_entry;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] hi_d, lo_d;
  logic              flush_w;
  logic              accept;
  logic              pop;
  logic              hilo_wr;
  logic [3:0]        opcode;

`ifdef EXMEM_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // in_ready comes straight from a flop (only the flush gate is combinational)
  assign in_ready = !skid_valid_q && !flush_w;
  assign accept   = in_valid && in_ready;
  assign pop      = main_valid_q && out_ready;
  assign opcode   = in_op[6:3];
  assign hilo_wr  = (in_op == OP_MULT) || (in_op == OP_MULTU) ||
                    (in_op == OP_DIV)  || (in_op == OP_DIVU);

  // Decode the incoming ALU word into a buffer entry; mfhi/mflo read the
  // committed HI/LO, which already reflect every earlier accepted write.
  always_comb begin
    new_entry            = '0;
    new_entry.data       = in_result;
    new_entry.rd         = in_rd;
    new_entry.store_data = in_store_data;
    new_entry.zero       = in_zero;
    new_entry.sign       = in_sign;
    if (in_op == OP_MFHI || in_op == OP_MFLO) begin
      new_entry.data = (in_op == OP_MFHI) ? hi_q : lo_q;
      new_entry.zero = (new_entry.data == '0);
      new_entry.sign = new_entry.data[DATA_W-1];
    end
    new_entry.we = !(hilo_wr || (in_op == OP_JR) || (opcode == OPC_BNEQ) ||
                     (opcode == OPC_BGTZ) || (opcode == OPC_LH) ||
                     (opcode == OPC_SH));
    new_entry.mem_rd       = (opcode == OPC_LH);
    new_entry.mem_wr       = (opcode == OPC_SH);
    new_entry.branch_taken = ((opcode == OPC_BNEQ) || (opcode == OPC_BGTZ)) &&
                             (in_result == DATA_W'(1));
  end

  // Main/skid steering: skid always drains into main before new input does.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_w) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = new_entry;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = new_entry;
      end
    end else if (accept) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
  end

  // HI/LO are written only by accepted mult/multu/div/divu
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (accept && hilo_wr) begin
      hi_d = in_hi;
      lo_d = in_lo;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign out_valid        = main_valid_q;
  assign out_data         = main_q.data;
  assign out_rd           = main_q.rd;
  assign out_we           = main_q.we;
  assign out_mem_rd       = main_q.mem_rd;
  assign out_mem_wr       = main_q.mem_wr;
  assign out_store_data   = main_q.store_data;
  assign out_branch_taken = main_q.branch_taken;
  assign out_zero         = main_q.zero;
  assign out_sign         = main_q.sign;

endmodule

// File: tb/tb_exmem_stage.sv
// Scoreboard bench for exmem_stage: directed vectors push hand-computed
// expected entries; a monitor pops and compares on every output transfer.
module tb_exmem_stage;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        we;
    logic        mrd;
    logic        mwr;
    logic [15:0] sd;
    logic        br;
    logic        z;
    logic        s;
  } exp_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  in_op;
  logic [15:0] in_result, in_hi, in_lo, in_store_data;
  logic        in_zero, in_sign;
  logic [2:0]  in_rd;
  logic        out_valid, out_ready;
  logic [15:0] out_data, out_store_data, hi_q, lo_q;
  logic [2:0]  out_rd;
  logic        out_we, out_mem_rd, out_mem_wr, out_branch_taken, out_zero, out_sign;
`ifdef EXMEM_FLUSH_EN
  logic        flush;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  exmem_stage #(.DATA_W(16), .RD_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef EXMEM_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_result(in_result), .in_hi(in_hi), .in_lo(in_lo),
    .in_zero(in_zero), .in_sign(in_sign), .in_rd(in_rd),
    .in_store_data(in_store_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_we(out_we), .out_mem_rd(out_mem_rd),
    .out_mem_wr(out_mem_wr), .out_store_data(out_store_data),
    .out_branch_taken(out_branch_taken), .out_zero(out_zero),
    .out_sign(out_sign), .hi_q(hi_q), .lo_q(lo_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] data, input logic [2:0] rd,
                              input logic we, input logic mrd, input logic mwr,
                              input logic [15:0] sd, input logic br,
                              input logic z, input logic s);
    exp_t e;
    e.data = data; e.rd = rd; e.we = we; e.mrd = mrd; e.mwr = mwr;
    e.sd = sd; e.br = br; e.z = z; e.s = s;
    return e;
  endfunction

  // Present one ALU word and wait (bounded) until it is accepted.
  // Returns 1 time unit after the accepting edge with in_valid still high.
  task automatic send(input logic [6:0] op, input logic [15:0] res,
                      input logic [15:0] hi, input logic [15:0] lo,
                      input logic z, input logic s, input logic [2:0] rd,
                      input logic [15:0] sd, input exp_t e);
    bit done;
    in_op = op; in_result = res; in_hi = hi; in_lo = lo;
    in_zero = z; in_sign = s; in_rd = rd; in_store_data = sd;
    in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: op %b never accepted", op);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Monitor: compare every transferred entry against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t act;
      exp_t e;
      act = mk(out_data, out_rd, out_we, out_mem_rd, out_mem_wr,
               out_store_data, out_branch_taken, out_zero, out_sign);
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_output: got %h, expected no entry", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          n_errors++;
          $display("FAIL out_entry: got %h, expected %h (t=%0t)", act, e, $time);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_result = '0; in_hi = '0; in_lo = '0;
    in_zero = 1'b0; in_sign = 1'b0; in_rd = '0; in_store_data = '0;
`ifdef EXMEM_FLUSH_EN
    flush = 1'b0;
`endif
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_hi", 32'(hi_q), 32'd0);
    chk("rst_lo", 32'(lo_q), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // HI/LO write and mfhi/mflo forwarding
    send(7'b0000_011, 16'h3400, 16'h0012, 16'h3400, 1'b0, 1'b0, 3'd1, 16'h0,
         mk(16'h3400, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0));
    chk("multu_hi", 32'(hi_q), 32'h0012);
    chk("multu_lo", 32'(lo_q), 32'h3400);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("latency_data", 32'(out_data), 32'h3400);
    send(7'b0010_110, 16'hAAAA, 16'h0, 16'h0, 1'b1, 1'b1, 3'd2, 16'h0,
         mk(16'h0012, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0));
    send(7'b0010_111, 16'hAAAA, 16'h0, 16'h0, 1'b1, 1'b1, 3'd3, 16'h0,
         mk(16'h3400, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0));
    send(7'b0000_010, 16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b0, 3'd4, 16'h0,
         mk(16'h0000, 3'd4, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0));
    send(7'b0010_111, 16'h1234, 16'h0, 16'h0, 1'b0, 1'b1, 3'd5, 16'h0,
         mk(16'h0000, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0));
    send(7'b0010_110, 16'h1234, 16'h0, 16'h0, 1'b1, 1'b0, 3'd6, 16'h0,
         mk(16'h8000, 3'd6, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1));
    send(7'b0001_011, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 3'd7, 16'h0,
         mk(16'h0000, 3'd7, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0));
    chk("divu0_hi", 32'(hi_q), 32'h0);
    chk("divu0_lo", 32'(lo_q), 32'h0);

    // Branches, memory ops and jr
    send(7'b0101_000, 16'h0001, 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0,
         mk(16'h0001, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0));
    send(7'b0110_000, 16'h0000, 16'h0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0,
         mk(16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0));
    send(7'b1001_000, 16'h0040, 16'h0, 16'h0, 1'b0, 1'b0, 3'd2, 16'hBEEF,
         mk(16'h0040, 3'd2, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0));
    send(7'b1000_000, 16'h0042, 16'h0, 16'h0, 1'b0, 1'b0, 3'd3, 16'h0,
         mk(16'h0042, 3'd3, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0));
    send(7'b0001_111, 16'h0100, 16'h0, 16'h0, 1'b0, 1'b0, 3'd1, 16'h0,
         mk(16'h0100, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0));
    chk("jr_no_hilo", 32'(hi_q), 32'h0);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: 1 in main, 2 in skid, 3 held upstream
    out_ready = 1'b0;
    send(7'b0000_001, 16'd1, 16'h0, 16'h0, 1'b0, 1'b0, 3'd1, 16'h0,
         mk(16'd1, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0));
    send(7'b0000_001, 16'd2, 16'h0, 16'h0, 1'b0, 1'b0, 3'd2, 16'h0,
         mk(16'd2, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0));
    chk("in_ready_fall", 32'(in_ready), 32'd0);
    in_result = 16'd3; in_rd = 3'd3;
    repeat (2) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_hold_data", 32'(out_data), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_skid_full_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("skid_to_main", 32'(out_data), 32'd2);
    chk("in_ready_rise", 32'(in_ready), 32'd1);
    send(7'b0000_001, 16'd3, 16'h0, 16'h0, 1'b0, 1'b0, 3'd3, 16'h0,
         mk(16'd3, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0));
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset with both entries full
    out_ready = 1'b0;
    send(7'b0000_010, 16'h0000, 16'hFFFF, 16'h1111, 1'b1, 1'b0, 3'd1, 16'h0,
         mk(16'h0000, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0));
    send(7'b0000_001, 16'd5, 16'h0, 16'h0, 1'b0, 1'b0, 3'd5, 16'h0,
         mk(16'd5, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0));
    idle();
    chk("pre_rst_hi", 32'(hi_q), 32'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_hi", 32'(hi_q), 32'd0);
    chk("async_rst_lo", 32'(lo_q), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

`ifdef EXMEM_FLUSH_EN
    // Flush with both entries full and a mult waiting
    send(7'b0000_010, 16'h0000, 16'h00AB, 16'h00CD, 1'b1, 1'b0, 3'd1, 16'h0,
         mk(16'h0000, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0));
    send(7'b0000_001, 16'd7, 16'h0, 16'h0, 1'b0, 1'b0, 3'd7, 16'h0,
         mk(16'd7, 3'd7, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0));
    in_op = 7'b0000_010; in_hi = 16'h4444; in_lo = 16'h5555; in_result = 16'd9;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    sb.delete();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready_next", 32'(in_ready), 32'd1);
    chk("flush_hi_kept", 32'(hi_q), 32'h00AB);
    chk("flush_lo_kept", 32'(lo_q), 32'h00CD);
    @(posedge clk); #1;
    chk("flush_no_capture", 32'(out_valid), 32'd0);
`endif

    // Final short stream under full throughput, then drain
    out_ready = 1'b1;
    send(7'b0000_001, 16'h00A1, 16'h0, 16'h0, 1'b0, 1'b0, 3'd1, 16'h0,
         mk(16'h00A1, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0));
    send(7'b0000_001, 16'h80A2, 16'h0, 16'h0, 1'b0, 1'b1, 3'd2, 16'h0,
         mk(16'h80A2, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1));
    idle();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
